// File: rtl/program_loader.sv
// Serial program loader: receives a length-prefixed word image over a byte link,
// writes it to program memory, then releases the CPU. Optional macro: LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [15:0] MEM_BASE  = 16'h0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        ByteValid,
    input  logic [7:0]  ByteData,
    output logic        ByteReady,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWriteData,
    output logic        MemWrite,
    output logic        CpuReset,
    output logic        Done,
    output logic        Error
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LEN_HI  = 3'd1;
    localparam logic [2:0] LEN_LO  = 3'd2;
    localparam logic [2:0] DATA_HI = 3'd3;
    localparam logic [2:0] DATA_LO = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK   = 3'd5;
    localparam logic [2:0] AFTER_DATA = CHECK;
`else
    localparam logic [2:0] AFTER_DATA = 3'd6;
`endif
    localparam logic [2:0] RUN     = 3'd6;
    localparam logic [2:0] FAULT   = 3'd7;

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [7:0]  hi_byte;
    logic [15:0] len_in;
    logic        xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    always_comb begin
        ByteReady = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO: ByteReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK: ByteReady = 1'b1;
`endif
            default: ByteReady = 1'b0;
        endcase
    end

    assign xfer     = ByteReady && ByteValid;
    assign len_in   = {len[15:8], ByteData};
    // Status outputs decode straight from the state register, no extra latency.
    assign CpuReset = (state != RUN);
    assign Done     = (state == RUN);
    assign Error    = (state == FAULT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            len          <= 16'd0;
            word_cnt     <= 16'd0;
            hi_byte      <= 8'd0;
            MemWrite     <= 1'b0;
            MemAddr      <= MEM_BASE;
            MemWriteData <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
        end else begin
            MemWrite <= 1'b0;
            case (state)
                IDLE, RUN, FAULT: begin
                    if (Start) begin
                        state    <= LEN_HI;
                        len      <= 16'd0;
                        word_cnt <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= 8'd0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= ByteData;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= ByteData;
                        if (32'(len_in) > MAX_WORDS) state <= FAULT;
                        else if (len_in != 16'd0)    state <= DATA_HI;
                        else                         state <= AFTER_DATA;
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= ByteData;
                        state   <= DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ ByteData;
`endif
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        // Address and data only move together with the write strobe.
                        MemWrite     <= 1'b1;
                        MemAddr      <= MEM_BASE + word_cnt;
                        MemWriteData <= {hi_byte, ByteData};
                        word_cnt     <= word_cnt + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= csum ^ ByteData;
`endif
                        state <= ((word_cnt + 16'd1) != len) ? DATA_HI : AFTER_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) state <= (ByteData == csum) ? RUN : FAULT;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (MAX_WORDS=4, MEM_BASE=0); follows LOADER_CHECKSUM_EN if defined.
module tb_program_loader;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ByteData = 8'd0;
    logic        ByteReady;
    logic [15:0] MemAddr, MemWriteData;
    logic        MemWrite, CpuReset, Done, Error;

    int total = 0;
    int bad = 0;
    int wr_n = 0;
    int stab_err = 0;
    int base;
    logic [15:0] wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    logic [15:0] prev_addr = 16'h0, prev_data = 16'h0;
    logic        rst_at_edge = 1'b1;

    program_loader #(.MEM_BASE(16'h0000), .MAX_WORDS(4)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .ByteValid(ByteValid),
        .ByteData(ByteData), .ByteReady(ByteReady), .MemAddr(MemAddr),
        .MemWriteData(MemWriteData), .MemWrite(MemWrite), .CpuReset(CpuReset),
        .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) rst_at_edge = Reset;

    // Record every write strobe and watch that address/data hold while the strobe is low.
    always @(negedge Clock) begin
        if (MemWrite) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = MemAddr;
                wr_data[wr_n] = MemWriteData;
            end
            wr_n++;
        end else if (!rst_at_edge && (MemAddr !== prev_addr || MemWriteData !== prev_data)) begin
            stab_err++;
        end
        prev_addr = MemAddr;
        prev_data = MemWriteData;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Present a byte after an idle gap; optionally fire Start inside the gap.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            Start = poke && (g == 0);
            tick();
            Start = 1'b0;
        end
        ByteValid = 1'b1;
        ByteData  = b;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (ByteReady) ok = 1'b1;
            tick();
        end
        ByteValid = 1'b0;
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_list(input logic [7:0] bytes [], input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[i], 0, 1'b0);
    endtask

    initial begin
        logic [7:0] img [];
        tick(); tick();
        Reset = 1'b0;
        chk("rst_ready", 32'(ByteReady), 32'd0);
        chk("rst_cpurst", 32'(CpuReset), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_memwr", 32'(MemWrite), 32'd0);
        chk("rst_addr", 32'(MemAddr), 32'h0000);
        chk("rst_wdata", 32'(MemWriteData), 32'h0000);

        // Two-word image
        base = wr_n;
        pulse_start();
        chk("t1_lenhi_ready", 32'(ByteReady), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
`else
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`endif
        send_list(img, img.size());
        tick();
        chk("t1_nwr", 32'(wr_n - base), 32'd2);
        chk("t1_a0", 32'(wr_addr[base]), 32'h0000);
        chk("t1_d0", 32'(wr_data[base]), 32'h1234);
        chk("t1_a1", 32'(wr_addr[base+1]), 32'h0001);
        chk("t1_d1", 32'(wr_data[base+1]), 32'hABCD);
        chk("t1_done", 32'(Done), 32'd1);
        chk("t1_cpurst", 32'(CpuReset), 32'd0);
        chk("t1_ready", 32'(ByteReady), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Same image, wrong checksum
        base = wr_n;
        pulse_start();
        chk("t2_cpurst_again", 32'(CpuReset), 32'd1);
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_list(img, img.size());
        tick();
        chk("t2_nwr", 32'(wr_n - base), 32'd2);
        chk("t2_d1", 32'(wr_data[base+1]), 32'hABCD);
        chk("t2_error", 32'(Error), 32'd1);
        chk("t2_cpurst", 32'(CpuReset), 32'd1);
        chk("t2_done", 32'(Done), 32'd0);
`endif

        // Length exactly MAX_WORDS is accepted
        base = wr_n;
        pulse_start();
`ifdef LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h04};
`else
        img = '{8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
`endif
        send_list(img, img.size());
        tick();
        chk("t3_nwr", 32'(wr_n - base), 32'd4);
        chk("t3_a3", 32'(wr_addr[base+3]), 32'h0003);
        chk("t3_d3", 32'(wr_data[base+3]), 32'h0004);
        chk("t3_done", 32'(Done), 32'd1);

        // Oversize length faults right after the second length byte
        base = wr_n;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        chk("t4_error", 32'(Error), 32'd1);
        chk("t4_ready", 32'(ByteReady), 32'd0);
        ByteValid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ByteValid = 1'b0;
        chk("t4_stuck", 32'(Error), 32'd1);
        chk("t4_nwr", 32'(wr_n - base), 32'd0);

        // Empty image, leaving FAULT through Start
        base = wr_n;
        pulse_start();
        chk("t5_left_fault", 32'(Error), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h00, 8'h00};
`else
        img = '{8'h00, 8'h00};
`endif
        send_list(img, img.size());
        tick();
        chk("t5_done", 32'(Done), 32'd1);
        chk("t5_nwr", 32'(wr_n - base), 32'd0);

        // Reset while the second word's low byte is pending
        base = wr_n;
        pulse_start();
        img = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        send_list(img, img.size());
        Reset = 1'b1;
        ByteValid = 1'b1;
        ByteData = 8'h44;
        tick();
        Reset = 1'b0;
        ByteValid = 1'b0;
        chk("t6_cpurst", 32'(CpuReset), 32'd1);
        chk("t6_ready", 32'(ByteReady), 32'd0);
        chk("t6_addr", 32'(MemAddr), 32'h0000);
        chk("t6_wdata", 32'(MemWriteData), 32'h0000);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_nwr", 32'(wr_n - base), 32'd1);
        chk("t6_d0", 32'(wr_data[base]), 32'h1122);
        chk("t6_idle", 32'(ByteReady), 32'd0);

        // Gapped transfer with Start pokes mid-load
        base = wr_n;
        pulse_start();
        send_byte(8'h00, 3, 1'b1);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hBE, 5, 1'b1);
        send_byte(8'hEF, 2, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h51, 4, 1'b1);
`endif
        tick();
        chk("t7_nwr", 32'(wr_n - base), 32'd1);
        chk("t7_a0", 32'(wr_addr[base]), 32'h0000);
        chk("t7_d0", 32'(wr_data[base]), 32'hBEEF);
        chk("t7_done", 32'(Done), 32'd1);
        chk("t7_cpurst", 32'(CpuReset), 32'd0);

        chk("hold_stable", 32'(stab_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEM_BASE, default 16'h0000, the word address where the first loaded word is written.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, the largest accepted image length in words.
REQ-003 SHALL have port Clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Start, input, 1, a one-cycle request to begin a load.
REQ-006 SHALL have port ByteValid, input, 1, which marks ByteData as valid.
REQ-007 SHALL have port ByteData, input, 8, a serial image byte from the host link.
REQ-008 SHALL have port ByteReady, output, 1, meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port MemAddr, output, 16, the program-memory word address.
REQ-010 SHALL have port MemWriteData, output, 16, the program-memory write word.
REQ-011 SHALL have port MemWrite, output, 1, a one-cycle program-memory write strobe.
REQ-012 SHALL have port CpuReset, output, 1, which drives the Reset input of the processor top level.
REQ-013 SHALL have port Done, output, 1, meaning the image is loaded and the processor is running.
REQ-014 SHALL have port Error, output, 1, meaning a load fault occurred.

Function
REQ-015 SHALL transfer a byte only in a cycle where both ByteValid and ByteReady are high.
REQ-016 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN and FAULT.
REQ-017 SHALL drive ByteReady high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
REQ-018 SHALL, on the image format, take the word count N first (big-endian, 16 bits), then N words high byte first, then one checksum byte when LOADER_CHECKSUM_EN is defined.
REQ-019 SHALL, on transitions, go IDLE->LEN_HI on Start, LEN_HI->LEN_LO on a transfer, and LEN_LO on a transfer to FAULT if N>MAX_WORDS, else to DATA_HI if N>0, else to CHECK or RUN per the configuration.
REQ-020 SHALL, on transitions, go DATA_HI->DATA_LO on a transfer, and DATA_LO on a transfer to DATA_HI if more words remain, else to CHECK or RUN.
REQ-021 SHALL, in the cycle after each DATA_LO transfer, pulse MemWrite for exactly one cycle with MemAddr = MEM_BASE + word index (index 0..N-1, modulo 2^16) and MemWriteData = {high, low}.
REQ-022 SHALL hold MemAddr and MemWriteData stable while MemWrite is low.
REQ-023 SHALL drive CpuReset = 1 in every state except RUN, decoded from the state register with no extra latency.
REQ-024 SHALL drive Done = 1 only in RUN and Error = 1 only in FAULT.
REQ-025 SHALL ignore Start in LEN_HI through CHECK, with no restart and no state change.
REQ-026 SHALL, on Start in RUN or FAULT, clear the counters and checksum, go to LEN_HI, and reassert CpuReset in the next cycle.
REQ-027 SHALL leave FAULT only through Start or Reset.
REQ-028 SHALL tolerate ByteValid gaps of any length, with no timeout.

Reset
REQ-029 SHALL, while Reset is high at a clock edge, enter IDLE and clear the word counter, length and checksum.
REQ-030 SHALL, while Reset is high at a clock edge, drive MemWrite=0, ByteReady=0, Done=0, Error=0, CpuReset=1, MemAddr=MEM_BASE and MemWriteData=0.
REQ-031 SHALL abort a load in progress on Reset with no further memory write; the words already written stay in memory.

Configuration
REQ-032 SHALL, when LOADER_CHECKSUM_EN is defined, keep a running XOR of all data bytes; in CHECK the transferred byte is compared, equal goes to RUN and unequal goes to FAULT.
REQ-033 SHALL, when LOADER_CHECKSUM_EN is undefined, have no CHECK state or checksum register, and SHALL go to RUN directly after the last data word or after N=0.

Verification
REQ-034 SHALL pass this scenario: checksum on, bytes 00 02 12 34 AB CD 40 -> writes (0000,1234) and (0001,ABCD), then RUN with Done=1 and CpuReset=0.
REQ-035 SHALL pass this scenario: the same image with checksum byte 41 -> both writes occur, then FAULT with Error=1, CpuReset=1 and Done=0.
REQ-036 SHALL pass this scenario: MAX_WORDS=4 and length 00 05 -> FAULT after the second length byte, with no MemWrite.
REQ-037 SHALL pass this scenario: length 00 00 plus checksum 00 -> RUN, with no MemWrite.
REQ-038 SHALL pass this scenario: Reset asserted mid-DATA_LO after one word -> IDLE, CpuReset=1, and no further writes.
REQ-039 SHALL pass this scenario: random ByteValid gaps on image 00 01 BE EF 51 -> a single write (0000,BEEF), Start pulses mid-load are ignored, then RUN.
